led_scan_controller: RTL and testbench

- Sequences the N×N LED array driver.
- Generates the column scan index `x` and a gated `ena`, with a blanking gap between columns to stop ghosting.
- Holds the displayed frame in a double buffer, so Game of Life generation updates only take effect at a frame boundary and the display never tears.
- Sits between the life-board core (producer of `cells`) and `led_array_driver`.

---
 rtl/led_scan_pkg.sv | 9 +
 rtl/led_frame_buffer.sv | 32 +++
 rtl/led_scan_controller.sv | 82 ++++++++
 tb/tb_led_scan_controller.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// led_scan_pkg: shared scan-state encoding and counter sizing for the LED scan controller
package led_scan_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ON} state_e;
  function automatic int cnt_w(input int blank, input int dwell);
    int m;
    m = blank > dwell ? blank : dwell;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/led_frame_buffer.sv
// led_frame_buffer: one-deep pending slot plus displayed-frame register, swapped on request
import led_scan_pkg::*;
module led_frame_buffer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cells_i,
  input  logic         valid_i,
  input  logic         swap_i,
  output logic         ready_o,
  output logic [W-1:0] cells_o
);
  logic [W-1:0] pend_q, disp_q;
  logic         full_q;
  logic         xfer, do_swap;
  assign ready_o = !full_q;
  assign xfer    = valid_i && !full_q;
  assign do_swap = swap_i && full_q;
  assign cells_o = disp_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      disp_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (xfer) pend_q <= cells_i;
      if (do_swap) disp_q <= pend_q;
      full_q <= do_swap ? 1'b0 : (xfer ? 1'b1 : full_q);
    end
  end
endmodule

// File: rtl/led_scan_controller.sv
// led_scan_controller: column scan FSM with blanking gap and frame-boundary double buffering
import led_scan_pkg::*;
module led_scan_controller #(
  parameter int N            = 8,
  parameter int DWELL_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [N*N-1:0]       cells_in,
  input  logic                 cells_valid,
  output logic                 cells_ready,
  output logic [$clog2(N):0]   x,
  output logic                 ena,
  output logic [N*N-1:0]       cells,
  output logic                 frame_done
);
  localparam int XW = $clog2(N) + 1;
  localparam int CW = cnt_w(BLANK_CYCLES, DWELL_CYCLES);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST  = XW'(N - 1);
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic          fd_q, fd_d;
  logic          swap;
  logic          last_col;
  assign last_col = x_q == X_LAST;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    x_d     = x_q;
    fd_d    = 1'b0;
    swap    = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d   = '0;
      x_d     = '0;
      swap    = 1'b1;
      state_d = run ? S_BLANK : S_IDLE;
    end else if (!run) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      x_d     = '0;
    end else if (state_q == S_BLANK && cnt_q == BL_LAST) begin
      state_d = S_ON;
      cnt_d   = '0;
    end else if (state_q == S_ON && cnt_q == ON_LAST) begin
      state_d = S_BLANK;
      cnt_d   = '0;
      x_d     = last_col ? '0 : x_q + 1'b1;
      fd_d    = last_col;
      swap    = last_col;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      fd_q    <= fd_d;
    end
  end
  assign x          = x_q;
  assign ena        = state_q == S_ON;
  assign frame_done = fd_q;
  led_frame_buffer #(.W(N*N)) u_fb (
    .clk     (clk),
    .rst     (rst),
    .cells_i (cells_in),
    .valid_i (cells_valid),
    .swap_i  (swap),
    .ready_o (cells_ready),
    .cells_o (cells)
  );
endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller: cycle scoreboard against a timeline model of the scan and frame buffer
module tb_led_scan_controller;
  localparam int N = 8, D = 4, B = 1, COL = B + D, FR = N * COL;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, cells_valid = 1'b0;
  logic cells_ready, ena, frame_done;
  logic [N*N-1:0] cells_in = '0, cells;
  logic [$clog2(N):0] x;
  typedef struct packed {
    logic [63:0] cells;
    logic [3:0]  x;
    logic        ena;
    logic        fd;
    logic        rdy;
  } exp_t;
  exp_t sb[$];
  int nvec = 0, nerr = 0;
  bit act = 0, pfull = 0, mfd = 0;
  int t = 0;
  logic [63:0] pend = '0, disp = '0;
  led_scan_controller #(.N(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .run(run), .cells_in(cells_in), .cells_valid(cells_valid),
    .cells_ready(cells_ready), .x(x), .ena(ena), .cells(cells), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask
  task automatic model(input logic r, input logic rn, input logic v, input logic [63:0] d);
    bit sw, xf;
    if (r) begin
      act = 0; t = 0; pfull = 0; disp = '0; mfd = 0;
      return;
    end
    xf = v && !pfull;
    sw = 0;
    mfd = 0;
    if (!act) begin
      sw = pfull; act = rn; t = 0;
    end else if (!rn) begin
      act = 0;
    end else begin
      mfd = (t % FR) == FR - 1;
      sw = mfd && pfull;
      t++;
    end
    if (sw) begin disp = pend; pfull = 0; end
    if (xf) begin pend = d; pfull = 1; end
  endtask
  function automatic exp_t expect_now();
    exp_t e;
    int p;
    p = t % FR;
    e.cells = disp;
    e.x     = act ? 4'(p / COL) : 4'd0;
    e.ena   = act && (p % COL) >= B;
    e.fd    = mfd;
    e.rdy   = !pfull;
    return e;
  endfunction
  task automatic cyc();
    logic r, rn, v;
    logic [63:0] d;
    exp_t e;
    r = rst; rn = run; v = cells_valid; d = cells_in;
    @(posedge clk);
    model(r, rn, v, d);
    sb.push_back(expect_now());
    #1;
    e = sb.pop_front();
    chk("cells", cells, e.cells);
    chk("x", {60'b0, x}, {60'b0, e.x});
    chk("ena", {63'b0, ena}, {63'b0, e.ena});
    chk("frame_done", {63'b0, frame_done}, {63'b0, e.fd});
    chk("cells_ready", {63'b0, cells_ready}, {63'b0, e.rdy});
  endtask
  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic wait_x(input int k);
    exp_t e;
    e = expect_now();
    for (int i = 0; i < 2 * FR && int'(e.x) != k; i++) begin
      cyc();
      e = expect_now();
    end
  endtask
  task automatic offer(input logic [63:0] d);
    cells_valid = 1'b1; cells_in = d;
    cyc();
    cells_valid = 1'b0;
  endtask
  initial begin
    cells_valid = 1'b1; cells_in = 64'h1;
    cycn(2);
    rst = 1'b0;
    chk("rst_ready", {63'b0, cells_ready}, 64'd1);
    chk("rst_cells", cells, 64'd0);
    cyc();
    cells_valid = 1'b0;
    cycn(2);
    chk("idle_swap1", cells, 64'h1);
    run = 1'b1;
    cycn(100);
    wait_x(3);
    offer(64'hFF);
    offer(64'hAA);
    cycn(3);
    wait_x(7);
    wait_x(0);
    chk("boundary_ff", cells, 64'hFF);
    offer(64'h5);
    wait_x(5);
    for (int i = 0; i < COL && !expect_now().ena; i++) cyc();
    run = 1'b0;
    cyc();
    chk("drop_ena", {63'b0, ena}, 64'd0);
    chk("drop_x", {60'b0, x}, 64'd0);
    cycn(3);
    chk("idle_swap5", cells, 64'h5);
    run = 1'b1;
    cycn(45);
    offer(64'h77);
    cycn(10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cycn(5);
    chk("rst_discard", cells, 64'h5 & 64'h0);
    cycn(60);
    for (int i = 0; i < 600; i++) begin
      run = $urandom_range(0, 49) != 0;
      cells_valid = $urandom_range(0, 7) == 0;
      cells_in = {$urandom, $urandom};
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout at %0t: got running expected finished", $time);
    $fatal(1, "timeout");
  end
endmodule
